// File: rtl/unidad_de_control_multiciclo.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// over a shared-memory datapath, with a memory-ready handshake and illegal-opcode flag.
module unidad_de_control_multiciclo #(
   parameter int OP_W        = 6,
   parameter int ALUOP_W     = 3,
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OP_W-1:0]    op,
   input  logic               MemReady,
   output logic               PCWrite,
   output logic               Branch,
   output logic [1:0]         PCSrc,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemToWrite,
   output logic               IRWrite,
   output logic               MemToReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               AluSrcA,
   output logic [1:0]         AluSrcB,
   output logic [ALUOP_W-1:0] AluOp,
   output logic               IllegalOp,
   output logic [3:0]         State
);

   // Handshake: a memory request (MemRead or MemToWrite) is held constant
   // until MemReady is seen high in the same cycle; the transfer completes on
   // that clock edge and the FSM advances.

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC_R = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_EXEC_I = 4'd10,
      S_IWB    = 4'd11,
      S_JUMP   = 4'd12
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
   localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
   localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
   localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(3'b001);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b010);
   localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b011);
   localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b100);
   localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b101);

   state_t r_state;

   logic w_mem_ready;
   logic w_is_r;
   logic w_is_mem;
   logic w_is_sw;
   logic w_is_beq;
   logic w_is_ialu;
   logic w_is_j;
   logic w_illegal;

   // Without wait support, every memory access completes in its first cycle.
   assign w_mem_ready = MEM_WAIT_EN ? MemReady : 1'b1;

   assign w_is_r    = (op == OP_RTYPE);
   assign w_is_sw   = (op == OP_SW);
   assign w_is_mem  = (op == OP_LW) || w_is_sw;
   assign w_is_beq  = (op == OP_BEQ);
   assign w_is_ialu = (op == OP_ADDI) || (op == OP_ANDI) ||
                      (op == OP_ORI)  || (op == OP_SLTI);
   assign w_is_j    = (op == OP_J);
   assign w_illegal = !(w_is_r || w_is_mem || w_is_beq || w_is_ialu || w_is_j);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   r_state <= S_FETCH;
            S_FETCH:  if (w_mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               if (w_is_r)         r_state <= S_EXEC_R;
               else if (w_is_mem)  r_state <= S_MEMADR;
               else if (w_is_beq)  r_state <= S_BRANCH;
               else if (w_is_ialu) r_state <= S_EXEC_I;
               else if (w_is_j)    r_state <= S_JUMP;
               else                r_state <= S_FETCH;
            end
            S_MEMADR: r_state <= w_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (w_mem_ready) r_state <= S_MEMWB;
            S_MEMWB:  r_state <= S_FETCH;
            S_MEMWR:  if (w_mem_ready) r_state <= S_FETCH;
            S_EXEC_R: r_state <= S_RWB;
            S_RWB:    r_state <= S_FETCH;
            S_BRANCH: r_state <= S_FETCH;
            S_EXEC_I: r_state <= S_IWB;
            S_IWB:    r_state <= S_FETCH;
            S_JUMP:   r_state <= S_FETCH;
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   // Outputs decode from the state register; only the FETCH-cycle
   // IRWrite/PCWrite also look at the memory handshake.
   always_comb begin
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      PCSrc      = 2'd0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemToWrite = 1'b0;
      IRWrite    = 1'b0;
      MemToReg   = 1'b0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      AluSrcA    = 1'b0;
      AluSrcB    = 2'd0;
      AluOp      = ALU_ADD;
      IllegalOp  = 1'b0;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            AluSrcB = 2'd1;
            IRWrite = w_mem_ready;
            PCWrite = w_mem_ready;
         end
         S_DECODE: begin
            AluSrcB   = 2'd3;
            IllegalOp = w_illegal;
         end
         S_MEMADR: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'd2;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemToReg = 1'b1;
         end
         S_MEMWR: begin
            MemToWrite = 1'b1;
            IorD       = 1'b1;
         end
         S_EXEC_R: begin
            AluSrcA = 1'b1;
            AluOp   = ALU_RTYPE;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BRANCH: begin
            AluSrcA = 1'b1;
            AluOp   = ALU_SUB;
            Branch  = 1'b1;
            PCSrc   = 2'd1;
         end
         S_EXEC_I: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'd2;
            if (op == OP_ANDI)      AluOp = ALU_AND;
            else if (op == OP_ORI)  AluOp = ALU_OR;
            else if (op == OP_SLTI) AluOp = ALU_SLT;
            else                    AluOp = ALU_ADD;
         end
         S_IWB: begin
            RegWrite = 1'b1;
         end
         S_JUMP: begin
            PCWrite = 1'b1;
            PCSrc   = 2'd2;
         end
         default: begin
         end
      endcase
   end

   assign State = r_state;

endmodule

// File: tb/tb_unidad_de_control_multiciclo.sv
// Directed bench for the multicycle control unit: per-scenario tables of
// state code and packed control word, hand-derived from the state definitions.
module tb_unidad_de_control_multiciclo;

   // Control word layout: {PCWrite, Branch, PCSrc[1:0], IorD, MemRead, MemToWrite,
   // IRWrite, MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB[1:0], AluOp[2:0], IllegalOp}
   localparam logic [17:0] C_ZERO    = 18'b0;
   localparam logic [17:0] C_FETCH   = 18'b1_0_00_0_1_0_1_0_0_0_0_01_000_0;
   localparam logic [17:0] C_FWAIT   = 18'b0_0_00_0_1_0_0_0_0_0_0_01_000_0;
   localparam logic [17:0] C_DECODE  = 18'b0_0_00_0_0_0_0_0_0_0_0_11_000_0;
   localparam logic [17:0] C_DEC_ILL = 18'b0_0_00_0_0_0_0_0_0_0_0_11_000_1;
   localparam logic [17:0] C_MEMADR  = 18'b0_0_00_0_0_0_0_0_0_0_1_10_000_0;
   localparam logic [17:0] C_MEMRD   = 18'b0_0_00_1_1_0_0_0_0_0_0_00_000_0;
   localparam logic [17:0] C_MEMWB   = 18'b0_0_00_0_0_0_0_1_0_1_0_00_000_0;
   localparam logic [17:0] C_MEMWR   = 18'b0_0_00_1_0_1_0_0_0_0_0_00_000_0;
   localparam logic [17:0] C_EXEC_R  = 18'b0_0_00_0_0_0_0_0_0_0_1_00_001_0;
   localparam logic [17:0] C_RWB     = 18'b0_0_00_0_0_0_0_0_1_1_0_00_000_0;
   localparam logic [17:0] C_BRANCH  = 18'b0_1_01_0_0_0_0_0_0_0_1_00_010_0;
   localparam logic [13:0] C_EXEC_HI = 14'b0_0_00_0_0_0_0_0_0_0_1_10;
   localparam logic [17:0] C_IWB     = 18'b0_0_00_0_0_0_0_0_0_1_0_00_000_0;
   localparam logic [17:0] C_JUMP    = 18'b1_0_10_0_0_0_0_0_0_0_0_00_000_0;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic [5:0] op       = 6'b0;
   logic       MemReady = 1'b0;
   logic       rst_n2   = 1'b0;
   logic [5:0] op2      = 6'b101011;
   logic       ready2   = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   logic       PCWrite, Branch, IorD, MemRead, MemToWrite, IRWrite;
   logic       MemToReg, RegDst, RegWrite, AluSrcA, IllegalOp;
   logic [1:0] PCSrc, AluSrcB;
   logic [2:0] AluOp;
   logic [3:0] State;

   logic       PCWrite2, Branch2, IorD2, MemRead2, MemToWrite2, IRWrite2;
   logic       MemToReg2, RegDst2, RegWrite2, AluSrcA2, IllegalOp2;
   logic [1:0] PCSrc2, AluSrcB2;
   logic [2:0] AluOp2;
   logic [3:0] State2;

   logic [17:0] w_ctrl;
   logic [17:0] w_ctrl2;

   assign w_ctrl  = {PCWrite, Branch, PCSrc, IorD, MemRead, MemToWrite, IRWrite,
                     MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, IllegalOp};
   assign w_ctrl2 = {PCWrite2, Branch2, PCSrc2, IorD2, MemRead2, MemToWrite2, IRWrite2,
                     MemToReg2, RegDst2, RegWrite2, AluSrcA2, AluSrcB2, AluOp2, IllegalOp2};

   always #5 clk = ~clk;

   unidad_de_control_multiciclo #(.OP_W(6), .ALUOP_W(3), .MEM_WAIT_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .MemReady(MemReady),
      .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .IorD(IorD),
      .MemRead(MemRead), .MemToWrite(MemToWrite), .IRWrite(IRWrite),
      .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
      .IllegalOp(IllegalOp), .State(State)
   );

   unidad_de_control_multiciclo #(.OP_W(6), .ALUOP_W(3), .MEM_WAIT_EN(1'b0)) dut_nw (
      .clk(clk), .rst_n(rst_n2), .op(op2), .MemReady(ready2),
      .PCWrite(PCWrite2), .Branch(Branch2), .PCSrc(PCSrc2), .IorD(IorD2),
      .MemRead(MemRead2), .MemToWrite(MemToWrite2), .IRWrite(IRWrite2),
      .MemToReg(MemToReg2), .RegDst(RegDst2), .RegWrite(RegWrite2),
      .AluSrcA(AluSrcA2), .AluSrcB(AluSrcB2), .AluOp(AluOp2),
      .IllegalOp(IllegalOp2), .State(State2)
   );

   task automatic test_reset();
      @(posedge clk); #1;
      n_vec++;
      if (State !== 4'd0 || w_ctrl !== C_ZERO) begin
         n_err++;
         $display("FAIL reset_hold: state=%0d ctrl=%b, expected state=0 ctrl=%b", State, w_ctrl, C_ZERO);
      end
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (State !== 4'd0) begin
         n_err++;
         $display("FAIL reset_release_idle: state=%0d, expected 0", State);
      end
      // Walk an sw into MEMWR with the memory stalled, then reset mid-write.
      MemReady = 1'b1; op = OP_SW;
      @(posedge clk); #1;
      n_vec++;
      if (State !== 4'd1 || w_ctrl !== C_FETCH) begin
         n_err++;
         $display("FAIL reset_first_fetch: state=%0d ctrl=%b, expected state=1 ctrl=%b", State, w_ctrl, C_FETCH);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      MemReady = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (State !== 4'd6 || w_ctrl !== C_MEMWR) begin
         n_err++;
         $display("FAIL reset_reach_memwr: state=%0d ctrl=%b, expected state=6 ctrl=%b", State, w_ctrl, C_MEMWR);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (State !== 4'd0 || MemToWrite !== 1'b0 || w_ctrl !== C_ZERO) begin
         n_err++;
         $display("FAIL reset_async_abort: state=%0d ctrl=%b, expected state=0 ctrl=%b", State, w_ctrl, C_ZERO);
      end
      @(posedge clk); #1;
      n_vec++;
      if (State !== 4'd0 || w_ctrl !== C_ZERO) begin
         n_err++;
         $display("FAIL reset_held_edge: state=%0d ctrl=%b, expected state=0 ctrl=%b", State, w_ctrl, C_ZERO);
      end
      rst_n = 1'b1; MemReady = 1'b1;
      #1;
      n_vec++;
      if (State !== 4'd0) begin
         n_err++;
         $display("FAIL reset_rerelease_idle: state=%0d, expected 0", State);
      end
      @(posedge clk); #1;
      n_vec++;
      if (State !== 4'd1 || w_ctrl !== C_FETCH) begin
         n_err++;
         $display("FAIL reset_refetch: state=%0d ctrl=%b, expected state=1 ctrl=%b", State, w_ctrl, C_FETCH);
      end
   endtask

   task automatic test_r_type();
      logic [3:0]  es  [5];
      logic [17:0] ec  [5];
      logic        rdy [5];
      es  = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
      ec  = '{C_FETCH, C_DECODE, C_EXEC_R, C_RWB, C_FWAIT};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         op = OP_R; MemReady = rdy[i];
         #1;
         n_vec++;
         if (State !== es[i] || w_ctrl !== ec[i]) begin
            n_err++;
            $display("FAIL r_type cyc%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, State, w_ctrl, es[i], ec[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_lw_wait();
      logic [3:0]  es  [9];
      logic [17:0] ec  [9];
      logic        rdy [9];
      es  = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
      ec  = '{C_FWAIT, C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB, C_FWAIT};
      rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 9; i++) begin
         op = OP_LW; MemReady = rdy[i];
         #1;
         n_vec++;
         if (State !== es[i] || w_ctrl !== ec[i]) begin
            n_err++;
            $display("FAIL lw_wait cyc%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, State, w_ctrl, es[i], ec[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sw_wait();
      logic [3:0]  es  [6];
      logic [17:0] ec  [6];
      logic        rdy [6];
      es  = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd1};
      ec  = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMWR, C_MEMWR, C_FWAIT};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         op = OP_SW; MemReady = rdy[i];
         #1;
         n_vec++;
         if (State !== es[i] || w_ctrl !== ec[i]) begin
            n_err++;
            $display("FAIL sw_wait cyc%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, State, w_ctrl, es[i], ec[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_jump();
      logic [3:0]  es  [7];
      logic [17:0] ec  [7];
      logic        rdy [7];
      logic [5:0]  opv [7];
      es  = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd12, 4'd1};
      ec  = '{C_FETCH, C_DECODE, C_BRANCH, C_FETCH, C_DECODE, C_JUMP, C_FWAIT};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      opv = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J, OP_J};
      for (int i = 0; i < 7; i++) begin
         op = opv[i]; MemReady = rdy[i];
         #1;
         n_vec++;
         if (State !== es[i] || w_ctrl !== ec[i]) begin
            n_err++;
            $display("FAIL branch_jump cyc%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, State, w_ctrl, es[i], ec[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_i_alu();
      logic [3:0]  es  [17];
      logic [17:0] ec  [17];
      logic        rdy [17];
      logic [5:0]  opv [17];
      logic [5:0]  ops  [4];
      logic [2:0]  alus [4];
      ops  = '{6'b001101, 6'b001100, 6'b001000, 6'b001010};
      alus = '{3'b100, 3'b011, 3'b000, 3'b101};
      for (int k = 0; k < 4; k++) begin
         es[4*k]   = 4'd1;  ec[4*k]   = C_FETCH;
         es[4*k+1] = 4'd2;  ec[4*k+1] = C_DECODE;
         es[4*k+2] = 4'd10; ec[4*k+2] = {C_EXEC_HI, alus[k], 1'b0};
         es[4*k+3] = 4'd11; ec[4*k+3] = C_IWB;
         for (int j = 0; j < 4; j++) begin
            rdy[4*k+j] = 1'b1;
            opv[4*k+j] = ops[k];
         end
      end
      es[16] = 4'd1; ec[16] = C_FWAIT; rdy[16] = 1'b0; opv[16] = ops[3];
      for (int i = 0; i < 17; i++) begin
         op = opv[i]; MemReady = rdy[i];
         #1;
         n_vec++;
         if (State !== es[i] || w_ctrl !== ec[i]) begin
            n_err++;
            $display("FAIL i_alu cyc%0d op=%b: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, opv[i], State, w_ctrl, es[i], ec[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      logic [3:0]  es  [5];
      logic [17:0] ec  [5];
      logic        rdy [5];
      logic [5:0]  opv [5];
      es  = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
      ec  = '{C_FETCH, C_DEC_ILL, C_FETCH, C_DEC_ILL, C_FWAIT};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      opv = '{6'b111111, 6'b111111, 6'b000001, 6'b000001, 6'b000001};
      for (int i = 0; i < 5; i++) begin
         op = opv[i]; MemReady = rdy[i];
         #1;
         n_vec++;
         if (State !== es[i] || w_ctrl !== ec[i]) begin
            n_err++;
            $display("FAIL illegal cyc%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, State, w_ctrl, es[i], ec[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_no_wait();
      logic [3:0]  es [5];
      logic [17:0] ec [5];
      es = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd1};
      ec = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMWR, C_FETCH};
      op2 = OP_SW; ready2 = 1'b0;
      rst_n2 = 1'b1;
      #1;
      n_vec++;
      if (State2 !== 4'd0 || w_ctrl2 !== C_ZERO) begin
         n_err++;
         $display("FAIL no_wait_idle: state=%0d ctrl=%b, expected state=0 ctrl=%b", State2, w_ctrl2, C_ZERO);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++;
         if (State2 !== es[i] || w_ctrl2 !== ec[i]) begin
            n_err++;
            $display("FAIL no_wait_sw cyc%0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, State2, w_ctrl2, es[i], ec[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_r_type();
      test_lw_wait();
      test_sw_wait();
      test_branch_jump();
      test_i_alu();
      test_illegal();
      test_no_wait();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
